// File: rtl/ff_pkg.sv
// Shared constants for the multimode flip-flop bank.
//   MODE_*  : run-time flip-flop behaviour select (2 bits)
//   SR_*    : S=R=1 conflict resolution policy in SR mode
package ff_pkg;

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [1:0] SR_HOLD = 2'd0;
    localparam logic [1:0] SR_SET  = 2'd1;
    localparam logic [1:0] SR_CLR  = 2'd2;

endpackage

// File: rtl/ff_next_cell.sv
// Single-bit next-state function for the multimode flip-flop bank.
// Purely combinational.
//   mode    : SR / JK / D / T select
//   a, b    : S/J/D/T and R/K inputs (b unused in D and T modes)
//   q       : current stored bit
//   policy  : SR conflict policy (hold / set / clear)
//   q_next  : value to store at the next enabled edge
//   illegal : S=R=1 seen in SR mode
module ff_next_cell
    import ff_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    input  logic       q,
    input  logic [1:0] policy,
    output logic       q_next,
    output logic       illegal
);

    always_comb begin
        q_next  = q;
        illegal = 1'b0;
        case (mode)
            MODE_SR: begin
                case ({a, b})
                    2'b10: q_next = 1'b1;
                    2'b01: q_next = 1'b0;
                    2'b11: begin
                        // Flag is raised whatever the policy decides for q.
                        illegal = 1'b1;
                        case (policy)
                            SR_SET:  q_next = 1'b1;
                            SR_CLR:  q_next = 1'b0;
                            default: q_next = q;
                        endcase
                    end
                    default: q_next = q;
                endcase
            end
            MODE_JK: begin
                case ({a, b})
                    2'b10:   q_next = 1'b1;
                    2'b01:   q_next = 1'b0;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            MODE_D:  q_next = a;
            default: q_next = q ^ a;
        endcase
    end

endmodule

// File: rtl/multimode_ff_bank.sv
// WIDTH-bit register bank whose bits act as SR, JK, D or T flip-flops,
// selected at run time by MODE, with clock enable, reset value, SR
// conflict policy, per-bit illegal flags and a sticky error bit.
//   CLK, RST_N : clock, async active-low reset
//   EN         : clock enable (0 = hold everything except ERR clear)
//   MODE       : 00 SR, 01 JK, 10 D, 11 T
//   A, B       : per-bit S/J/D/T and R/K inputs
//   ERR_CLR    : synchronous clear of ERR (wins over a new event)
//   Q, Q_bar   : registered state and its inverse
//   ILLEGAL    : per-bit S=R=1 flag from the last enabled edge
//   ERR        : sticky OR of illegal events
module multimode_ff_bank
    import ff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               SR_POLICY = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ERR_CLR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic [WIDTH-1:0] ILLEGAL,
    output logic             ERR
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("multimode_ff_bank: WIDTH must be at least 1");
        end
    endgenerate

    // Policy 3 (and anything else unknown) falls back to hold.
    localparam logic [1:0] POLICY = (SR_POLICY == 1) ? SR_SET :
                                    (SR_POLICY == 2) ? SR_CLR : SR_HOLD;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] illegal_q, illegal_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] cell_q_next;
    logic [WIDTH-1:0] cell_illegal;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_next_cell u_cell (
            .mode    (MODE),
            .a       (A[i]),
            .b       (B[i]),
            .q       (q_q[i]),
            .policy  (POLICY),
            .q_next  (cell_q_next[i]),
            .illegal (cell_illegal[i])
        );
    end

    always_comb begin
        q_d       = q_q;
        illegal_d = illegal_q;
        err_d     = err_q;
        if (EN) begin
            q_d       = cell_q_next;
            illegal_d = cell_illegal;
        end
        if (ERR_CLR) begin
            err_d = 1'b0;
        end else if (EN) begin
            err_d = err_q | (|cell_illegal);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_q       <= RESET_VAL;
            illegal_q <= '0;
            err_q     <= 1'b0;
        end else begin
            q_q       <= q_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
        end
    end

    assign Q       = q_q;
    assign Q_bar   = ~q_q;
    assign ILLEGAL = illegal_q;
    assign ERR     = err_q;

endmodule
